// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake game-state block.
package snake_pkg;

  localparam int unsigned DEF_GRID_W = 80;
  localparam int unsigned DEF_GRID_H = 60;

  typedef logic [6:0]  coord_x_t;
  typedef logic [5:0]  coord_y_t;
  typedef logic [12:0] cell_addr_t;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    CLEAR  = 3'd0,
    SEED   = 3'd1,
    IDLE   = 3'd2,
    LOOKUP = 3'd3,
    CHECK  = 3'd4,
    TAIL   = 3'd5,
    HEAD   = 3'd6
  } state_t;

  // Linear bitmap address of a grid cell: y*grid_w + x.
  function automatic cell_addr_t cell_addr(input coord_x_t x, input coord_y_t y,
                                           input int unsigned grid_w);
    return cell_addr_t'(y) * cell_addr_t'(grid_w) + cell_addr_t'(x);
  endfunction

  // Opposite heading: UP<->DOWN, RIGHT<->LEFT differ only in bit 1.
  function automatic dir_t dir_reverse(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/snake_body_occupancy_ram.sv
// One-bit occupancy RAM: port A synchronous read-only for renderer
// queries, port B read/write for the game FSM. No reset; contents are
// cleared by the FSM. A read of the cell being written returns the old bit.
module occupancy_ram
  import snake_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_GRID_W * DEF_GRID_H
) (
  input  logic       clk_i,
  input  cell_addr_t a_addr_i,
  output logic       a_rdata_o,
  input  cell_addr_t b_addr_i,
  input  logic       b_we_i,
  input  logic       b_wdata_i,
  output logic       b_rdata_o
);

  logic mem [DEPTH];

  // Port A: registered query read.
  always_ff @(posedge clk_i) begin
    a_rdata_o <= mem[a_addr_i];
  end

  // Port B: read-before-write access for the FSM.
  always_ff @(posedge clk_i) begin
    if (b_we_i) begin
      mem[b_addr_i] <= b_wdata_i;
    end
    b_rdata_o <= mem[b_addr_i];
  end

endmodule

// File: rtl/snake_body.sv
// Snake body state: occupancy bitmap, {x,y} ring buffer, stepping FSM.
// Define SNAKE_WRAP_EN to wrap the head across grid edges instead of
// treating an off-grid step as a collision.
module snake_body
  import snake_pkg::*;
#(
  parameter int unsigned GRID_W    = DEF_GRID_W,
  parameter int unsigned GRID_H    = DEF_GRID_H,
  parameter int unsigned MAX_LEN   = 64,
  parameter int unsigned START_X   = 40,
  parameter int unsigned START_Y   = 30,
  parameter int unsigned START_LEN = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic [1:0] dir_in,
  input  logic       grow,
  input  logic [6:0] query_x,
  input  logic [5:0] query_y,
  output logic       query_hit,
  output logic [6:0] head_x,
  output logic [5:0] head_y,
  output logic [6:0] length,
  output logic       dead,
  output logic       busy
);

  localparam int unsigned PW    = $clog2(MAX_LEN);
  localparam int unsigned DEPTH = GRID_W * GRID_H;

  state_t     state_q, state_d;
  cell_addr_t clr_q, clr_d;
  logic [6:0] seed_q, seed_d;
  logic [PW-1:0] head_ptr_q, head_ptr_d;
  logic [PW-1:0] tail_ptr_q, tail_ptr_d;
  coord_x_t   head_x_q, head_x_d;
  coord_y_t   head_y_q, head_y_d;
  logic [6:0] len_q, len_d;
  logic       dead_q, dead_d;
  dir_t       dir_q, dir_d;
  logic       grow_q, grow_d;
  logic       q_valid_q;

  coord_x_t ring_x [MAX_LEN];
  coord_y_t ring_y [MAX_LEN];
  logic          ring_we;
  logic [PW-1:0] ring_wptr;
  coord_x_t      ring_wx;
  coord_y_t      ring_wy;

  cell_addr_t b_addr;
  logic       b_we, b_wdata, b_rdata, a_rdata;
  logic       q_in_range;
  cell_addr_t q_addr;

  logic signed [7:0] nx_s, ny_s;
  logic x_neg, x_hi, y_neg, y_hi;
  logic wall_hit;
  coord_x_t nx, tail_x, seed_x;
  coord_y_t ny, tail_y;
  cell_addr_t next_addr, tail_addr, seed_addr;
  logic next_is_tail, collide;

  // Candidate next head: signed +/-1 on one axis, then range-folded.
  always_comb begin
    nx_s = $signed({1'b0, head_x_q});
    ny_s = $signed({2'b00, head_y_q});
    unique case (dir_q)
      UP:    ny_s = ny_s - 8'sd1;
      RIGHT: nx_s = nx_s + 8'sd1;
      DOWN:  ny_s = ny_s + 8'sd1;
      LEFT:  nx_s = nx_s - 8'sd1;
    endcase
    x_neg = nx_s[7];
    y_neg = ny_s[7];
    x_hi  = !nx_s[7] && (nx_s[6:0] >= coord_x_t'(GRID_W));
    y_hi  = !ny_s[7] && (ny_s[6:0] >= 7'(GRID_H));
    nx    = x_neg ? coord_x_t'(GRID_W - 1) : (x_hi ? '0 : nx_s[6:0]);
    ny    = y_neg ? coord_y_t'(GRID_H - 1) : (y_hi ? '0 : ny_s[5:0]);
  end

`ifdef SNAKE_WRAP_EN
  assign wall_hit = 1'b0;
`else
  assign wall_hit = x_neg | x_hi | y_neg | y_hi;
`endif

  assign tail_x       = ring_x[tail_ptr_q];
  assign tail_y       = ring_y[tail_ptr_q];
  assign seed_x       = coord_x_t'(START_X - START_LEN + 1) + seed_q;
  assign next_addr    = cell_addr(nx, ny, GRID_W);
  assign tail_addr    = cell_addr(tail_x, tail_y, GRID_W);
  assign seed_addr    = cell_addr(seed_x, coord_y_t'(START_Y), GRID_W);
  assign next_is_tail = (nx == tail_x) && (ny == tail_y);
  // Moving onto a tail that vacates this same step is legal.
  assign collide      = wall_hit || (b_rdata && !(next_is_tail && !grow_q));

  assign q_in_range = (query_x < coord_x_t'(GRID_W)) && (query_y < coord_y_t'(GRID_H));
  assign q_addr     = q_in_range ? cell_addr(query_x, query_y, GRID_W) : '0;

  // FSM next-state, bitmap port B and ring-buffer write control.
  always_comb begin
    state_d    = state_q;
    clr_d      = clr_q;
    seed_d     = seed_q;
    head_ptr_d = head_ptr_q;
    tail_ptr_d = tail_ptr_q;
    head_x_d   = head_x_q;
    head_y_d   = head_y_q;
    len_d      = len_q;
    dead_d     = dead_q;
    dir_d      = dir_q;
    grow_d     = grow_q;
    b_addr     = '0;
    b_we       = 1'b0;
    b_wdata    = 1'b0;
    ring_we    = 1'b0;
    ring_wptr  = '0;
    ring_wx    = '0;
    ring_wy    = '0;
    unique case (state_q)
      CLEAR: begin
        b_addr = clr_q;
        b_we   = 1'b1;
        if (clr_q == cell_addr_t'(DEPTH - 1)) begin
          clr_d   = '0;
          state_d = SEED;
        end else begin
          clr_d = clr_q + cell_addr_t'(1);
        end
      end
      SEED: begin
        b_addr    = seed_addr;
        b_we      = 1'b1;
        b_wdata   = 1'b1;
        ring_we   = 1'b1;
        ring_wptr = PW'(seed_q);
        ring_wx   = seed_x;
        ring_wy   = coord_y_t'(START_Y);
        if (seed_q == 7'(START_LEN - 1)) begin
          seed_d  = '0;
          state_d = IDLE;
        end else begin
          seed_d = seed_q + 7'd1;
        end
      end
      IDLE: begin
        if (tick && !dead_q) begin
          grow_d = grow && (len_q != 7'(MAX_LEN));
          if (dir_t'(dir_in) != dir_reverse(dir_q)) begin
            dir_d = dir_t'(dir_in);
          end
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        b_addr  = next_addr;
        state_d = CHECK;
      end
      CHECK: begin
        if (collide) begin
          dead_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = TAIL;
        end
      end
      TAIL: begin
        b_addr = tail_addr;
        b_we   = !grow_q;
        if (!grow_q) begin
          tail_ptr_d = tail_ptr_q + PW'(1);
        end
        state_d = HEAD;
      end
      HEAD: begin
        b_addr     = next_addr;
        b_we       = 1'b1;
        b_wdata    = 1'b1;
        ring_we    = 1'b1;
        ring_wptr  = head_ptr_q + PW'(1);
        ring_wx    = nx;
        ring_wy    = ny;
        head_ptr_d = head_ptr_q + PW'(1);
        head_x_d   = nx;
        head_y_d   = ny;
        if (grow_q) begin
          len_d = len_q + 7'd1;
        end
        state_d = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  // Control and game-state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= CLEAR;
      clr_q      <= '0;
      seed_q     <= '0;
      head_ptr_q <= PW'(START_LEN - 1);
      tail_ptr_q <= '0;
      head_x_q   <= coord_x_t'(START_X);
      head_y_q   <= coord_y_t'(START_Y);
      len_q      <= 7'(START_LEN);
      dead_q     <= 1'b0;
      dir_q      <= RIGHT;
      grow_q     <= 1'b0;
      q_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_q      <= clr_d;
      seed_q     <= seed_d;
      head_ptr_q <= head_ptr_d;
      tail_ptr_q <= tail_ptr_d;
      head_x_q   <= head_x_d;
      head_y_q   <= head_y_d;
      len_q      <= len_d;
      dead_q     <= dead_d;
      dir_q      <= dir_d;
      grow_q     <= grow_d;
      q_valid_q  <= q_in_range && (state_q != CLEAR);
    end
  end

  // Body ring buffer; storage only, contents rebuilt by SEED.
  always_ff @(posedge clk) begin
    if (ring_we) begin
      ring_x[ring_wptr] <= ring_wx;
      ring_y[ring_wptr] <= ring_wy;
    end
  end

  occupancy_ram #(
    .DEPTH (DEPTH)
  ) u_occ (
    .clk_i     (clk),
    .a_addr_i  (q_addr),
    .a_rdata_o (a_rdata),
    .b_addr_i  (b_addr),
    .b_we_i    (b_we),
    .b_wdata_i (b_wdata),
    .b_rdata_o (b_rdata)
  );

  assign query_hit = q_valid_q & a_rdata;
  assign head_x    = head_x_q;
  assign head_y    = head_y_q;
  assign length    = len_q;
  assign dead      = dead_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/snake_body.md
# snake_body

Game-state stage directly upstream of the snake renderer: holds the snake body on the 80×60 block grid, advances it one cell per game tick, grows it on request and flags self- or wall-collision. The renderer indexes the occupancy map with its current block coordinates and gets a registered `query_hit` bit to colour the pixel. The renderer's frame divider supplies `tick`; its food logic drives `grow`.

## Interface
- `GRID_W`, 80: grid width in blocks (`x` 0..79).
- `GRID_H`, 60: grid height in blocks (`y` 0..59).
- `MAX_LEN`, 64: ring-buffer depth and maximum length; power of two.
- `START_X`, 40 / `START_Y`, 30: initial head cell.
- `START_LEN`, 3: initial length; 1..`MAX_LEN`.
- `clk` in 1: single clock.
- `reset_n` in 1: reset, asynchronous and active-low.
- `tick` in 1: one-cycle game-step pulse.
- `dir_in` in 2: requested direction (0 up, 1 right, 2 down, 3 left).
- `grow` in 1: sampled with `tick`; lengthens the snake by one on that step.
- `query_x` in 7 / `query_y` in 6: renderer lookup cell.
- `query_hit` out 1: occupancy of the queried cell, 1-cycle latency.
- `head_x` out 7 / `head_y` out 6: current head cell.
- `length` out 7: current length.
- `dead` out 1: sticky collision flag.
- `busy` out 1: high during init and during a step; ticks are dropped while high.

## Operation
- Storage: occupancy bitmap of `GRID_W`*`GRID_H` bits, address `y*GRID_W + x` (13 bits); ring buffer of `MAX_LEN` {x,y} entries with `head_ptr`, `tail_ptr` and `length`.
- Reset values: `head_x`=`START_X`, `head_y`=`START_Y`, `length`=`START_LEN`, `dead`=0, `busy`=1, `query_hit`=0, current direction = right, state CLEAR.
- FSM states:
  - CLEAR: writes 0 to every address, one per cycle.
  - SEED: writes the `START_LEN` cells (`START_X-START_LEN+1`..`START_X`, `START_Y`), tail first, into the bitmap and ring buffer.
  - IDLE: waits for a step.
  - LOOKUP: reads the bitmap at the next head cell.
  - CHECK: evaluates collision.
  - TAIL: clears the old tail when not growing.
  - HEAD: writes the new head.
- Accepting a step: `tick` in IDLE with `dead`=0 latches `grow`, then commits `dir_in` unless it is the exact reverse of the current direction; a reverse request keeps the current direction.
- Next head: current head ±1 on one axis, computed as 8-bit signed before the range check.
- Collision: the next cell is occupied, or it is off-grid (see Configuration).
  - Exception: the next cell equals the current tail and the step is not growing. The tail vacates, so this is not a collision.
- On collision: `dead`←1, nothing is written, the FSM returns to IDLE. `dead` stays set until reset.
- Growing step: `length`+1 and the tail is kept. `grow` at `length`==`MAX_LEN` is treated as not growing.
- Non-growing step: tail cell bitmap ←0, `tail_ptr`+1.
- Both pointers wrap modulo `MAX_LEN`.
- `tick` while `busy`=1 or `dead`=1 is ignored (not queued).
- `reset_n` low at any time, including mid-step or mid-CLEAR, returns every register to its reset value immediately. CLEAR restarts when `reset_n` rises.

## Timing
- `tick` sampled in IDLE at cycle T. Cycles T+1..T+4 are LOOKUP, CHECK, TAIL, HEAD, with `busy`=1 throughout.
- `head_x`, `head_y`, `length` update at T+5; `busy` returns to 0 at T+5.
- Collision: `dead`=1 at T+3 and `busy`=0 at T+3.
- Init: `busy` stays high for `GRID_W`*`GRID_H`+`START_LEN` = 4803 cycles after `reset_n` rises.
- Query port is independent of the update port. `query_hit` at cycle N+1 reflects `query_x`/`query_y` at N.
  - A query to the cell being written in the same cycle returns the old value.
- `query_hit` reads 0 for off-grid query coordinates (x≥80 or y≥60) and during CLEAR.

## Configuration
- `SNAKE_WRAP_EN` defined: an off-grid next head wraps (x −1→79, 80→0; y −1→59, 60→0), then is checked for occupancy as usual.
- `SNAKE_WRAP_EN` undefined: an off-grid next head sets `dead`, matching the renderer's blue play-edge border.

## Structure
- Package `snake_pkg` holds:
  - `dir_t` enum (UP, RIGHT, DOWN, LEFT);
  - `GRID_W`/`GRID_H` defaults and the `coord_x_t` (7-bit) and `coord_y_t` (6-bit) types;
  - the FSM state enum;
  - a `cell_addr` function implementing `y*GRID_W+x`.
- Sub-module `occupancy_ram`: one-bit-wide dual-port RAM. Port A is read-only with a synchronous read for queries; port B is read/write for the FSM. It has no reset; clearing is done by the CLEAR state.

## Test plan
- Reset then wait 4803 cycles → `busy`=0, `length`=3; queries at (38..40,30) give `query_hit`=1 and (41,30) gives 0.
- `dir_in`=1 and one `tick` → at T+5 `head_x`=41, `length`=3; `query_hit`(38,30)=0 and (41,30)=1.
- `tick` with `grow`=1 ×2 → `length`=5; with `length`=64 and `grow`=1 → `length` stays 64.
- From head moving right, `dir_in`=3 (reverse) plus `tick` → head moves right to x+1 and `dead`=0.
  - A second `tick` one cycle after the first (`busy`=1) is ignored: only one step occurs.
- Steer into own body (length 5: up, left, down) → `dead`=1 at T+3; further ticks leave head and `length` unchanged.
- Head at x=79 moving right plus `tick` → with `SNAKE_WRAP_EN`, `head_x`=0 and `dead`=0; without it, `dead`=1. `reset_n` low mid-step → all outputs return to reset values.
